// File: rtl/im_loader_if.sv
// Loader bus: command/byte-stream inputs, instruction-memory write port and status.
interface im_loader_if;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;

    // Loader side
    modport slave (
        input  start, in_valid, in_data,
        output in_ready, im_we, im_addr, im_wdata, cpu_reset, done, err
    );

    // Host / stream source side
    modport master (
        output start, in_valid, in_data,
        input  in_ready, im_we, im_addr, im_wdata, cpu_reset, done, err
    );
endinterface

// File: rtl/im_loader.sv
// Instruction-memory image loader: takes a word count N followed by 4*N
// big-endian bytes and writes them as words from BASE_ADDR up. The CPU is
// held in reset until the whole image has been written.
module im_loader #(
    parameter int          DEPTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic         i_clk,
    input  logic         i_reset,
    im_loader_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_BYTES, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t      r_state;
    logic [7:0]  r_n;
    logic [7:0]  r_idx;
    logic [1:0]  r_bcnt;
    logic [23:0] r_word;      // first three bytes of the word being assembled
    logic        r_in_ready;
    logic        r_im_we;
    logic [31:0] r_im_addr;
    logic [31:0] r_im_wdata;
    logic        r_cpu_reset;
    logic        r_done;
    logic        r_err;

    logic        w_take;
    logic        w_len_bad;

    assign w_take    = bus.in_valid && r_in_ready;
    assign w_len_bad = (bus.in_data == 8'd0) || ({1'b0, bus.in_data} > 9'(DEPTH));

    assign bus.in_ready  = r_in_ready;
    assign bus.im_we     = r_im_we;
    assign bus.im_addr   = r_im_addr;
    assign bus.im_wdata  = r_im_wdata;
    assign bus.cpu_reset = r_cpu_reset;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

    // Load FSM; every output is registered and set on entry to the state that owns it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_idx       <= '0;
            r_bcnt      <= '0;
            r_word      <= '0;
            r_in_ready  <= 1'b0;
            r_im_we     <= 1'b0;
            r_im_addr   <= BASE_ADDR;
            r_im_wdata  <= '0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        r_state     <= S_LEN;
                        r_in_ready  <= 1'b1;
                        r_cpu_reset <= 1'b1;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                    end
                end
                S_LEN: begin
                    if (w_take) begin
                        if (w_len_bad) begin
                            r_state    <= S_ERR;
                            r_in_ready <= 1'b0;
                            r_err      <= 1'b1;
                        end else begin
                            r_state <= S_BYTES;
                            r_n     <= bus.in_data;
                            r_idx   <= '0;
                            r_bcnt  <= '0;
                        end
                    end
                end
                S_BYTES: begin
                    if (w_take) begin
                        r_word <= {r_word[15:0], bus.in_data};
                        r_bcnt <= r_bcnt + 2'd1;
                        // Fourth byte: the write happens next cycle with the completed word.
                        if (r_bcnt == 2'd3) begin
                            r_state    <= S_WRITE;
                            r_in_ready <= 1'b0;
                            r_im_we    <= 1'b1;
                            r_im_wdata <= {r_word, bus.in_data};
                            r_im_addr  <= BASE_ADDR + {22'd0, r_idx, 2'b00};
                            r_idx      <= r_idx + 8'd1;
                        end
                    end
                end
                S_WRITE: begin
                    r_im_we <= 1'b0;
                    r_bcnt  <= '0;
                    if (r_idx == r_n) begin
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_cpu_reset <= 1'b0;
                    end else begin
                        r_state    <= S_BYTES;
                        r_in_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected writes are queued as bytes are
// driven and popped by a monitor on every im_we pulse.
module tb_im_loader;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    im_loader_if bus ();

    im_loader #(.DEPTH(32), .BASE_ADDR(BASE)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Monitor: every write must match the next queued expectation.
    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            chk("ready_in_write", 32'(bus.in_ready), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", bus.im_addr, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", bus.im_addr, e.addr);
                chk("wr_data", bus.im_wdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Offer one byte until accepted; optional random idle cycles first.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok = 1'b0;
        if (gaps) begin
            int g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                tick();
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int t = 0; t < 100 && !ok; t++) begin
            ok = (bus.in_ready === 1'b1);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        if (!ok) chk("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic load(input int n, input bit gaps, input bit poke_start);
        do_start();
        send_byte(8'(n), gaps);
        for (int w = 0; w < n; w++) begin
            logic [31:0] word;
            wr_t e;
            word = (n == 2 && !gaps && !poke_start) ? ((w == 0) ? 32'h0000_8821 : 32'h1234_5678) : $urandom;
            e.addr = BASE + 32'(4 * w);
            e.data = word;
            exp_q.push_back(e);
            if (poke_start && w == 0) do_start();
            for (int b = 0; b < 4; b++) send_byte(word[31 - 8*b -: 8], gaps);
        end
        // Last byte accepted; next cycle is WRITE, the one after is DONE.
        tick();
        chk("done", 32'(bus.done), 32'd1);
        chk("cpu_reset_done", 32'(bus.cpu_reset), 32'd0);
        chk("err_done", 32'(bus.err), 32'd0);
        chk("ready_done", 32'(bus.in_ready), 32'd0);
        chk("q_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic expect_err(input logic [7:0] n);
        do_start();
        send_byte(n, 1'b0);
        chk("err", 32'(bus.err), 32'd1);
        chk("cpu_reset_err", 32'(bus.cpu_reset), 32'd1);
        chk("ready_err", 32'(bus.in_ready), 32'd0);
        chk("done_err", 32'(bus.done), 32'd0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        // Reset, with start and in_valid asserted to show reset wins.
        tick();
        bus.start = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_we", 32'(bus.im_we), 32'd0);
        chk("rst_addr", bus.im_addr, BASE);
        chk("rst_wdata", bus.im_wdata, 32'd0);
        chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);

        // Two-word directed image.
        load(2, 1'b0, 1'b0);

        // Zero length, then a single word.
        expect_err(8'h00);
        load(1, 1'b0, 1'b0);

        // One past capacity, then exactly capacity.
        expect_err(8'h21);
        load(32, 1'b0, 1'b0);
        chk("addr_hold", bus.im_addr, 32'h0000_307C);

        // Irregular in_valid.
        load(3, 1'b1, 1'b0);

        // Reset after two bytes of the first word.
        do_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        bus.in_valid = 1'b0;
        chk("abort_ready", 32'(bus.in_ready), 32'd0);
        chk("abort_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("abort_done", 32'(bus.done), 32'd0);
        load(2, 1'b1, 1'b0);

        // start during BYTES, then in_valid held high in DONE.
        load(2, 1'b0, 1'b1);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("done_hold", 32'(bus.done), 32'd1);
            chk("done_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("q_final", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter DEPTH, default 32, is the instruction-memory capacity in 32-bit words (legal 1..255).
REQ-002 Parameter BASE_ADDR, default 32'h0000_3000, is the byte address of word 0, equal to the PC reset value.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream data.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 im_addr  output  32  instruction-memory byte address, word aligned.
REQ-011 im_wdata  output  32  instruction word to write.
REQ-012 cpu_reset  output  1  hold for the CPU reset; high while the image is not valid.
REQ-013 done  output  1  image fully written.
REQ-014 err  output  1  illegal length received.

Function
REQ-015 A byte transfers only on a rising edge with in_valid=1 and in_ready=1; in_data is ignored otherwise.
REQ-016 States: IDLE, LEN, BYTES, WRITE, DONE, ERR.
REQ-017 IDLE: in_ready=0; start=1 -> LEN.
REQ-018 LEN: in_ready=1; the first accepted byte is N, the word count; N=0 or N>DEPTH -> ERR; otherwise latch N, clear the word index and byte count, -> BYTES.
REQ-019 BYTES: in_ready=1; bytes are assembled big-endian (1st byte -> [31:24], 4th byte -> [7:0]); on acceptance of the 4th byte -> WRITE.
REQ-020 WRITE: in_ready=0, im_we=1 for exactly one cycle, im_wdata = assembled word, im_addr = BASE_ADDR + 4*index (32-bit arithmetic, no wrap within DEPTH); index increments.
REQ-021 After WRITE: if index == N, go to DONE; otherwise return to BYTES.
REQ-022 Latency: the write pulse occurs in the cycle after the 4th byte is accepted; back-to-back valid bytes sustain one word per 5 cycles.
REQ-023 DONE: done=1, cpu_reset=0, in_ready=0.
REQ-024 ERR: err=1, cpu_reset=1, in_ready=0.
REQ-025 In DONE or ERR, start=1 -> LEN, with done=0, err=0 and cpu_reset=1 from the next cycle.
REQ-026 start is ignored in LEN, BYTES and WRITE; in_valid is ignored in IDLE, WRITE, DONE and ERR.
REQ-027 cpu_reset=1 in every state except DONE; it deasserts in the cycle after the last WRITE.
REQ-028 im_we=0 in every state except WRITE.
REQ-029 im_addr and im_wdata hold their last written values outside WRITE.
REQ-030 A partial word (fewer than 4 bytes) is never written.
REQ-031 Words beyond N are not written; bytes offered after DONE are not accepted.

Reset
REQ-032 On reset=1 at a clock edge: state=IDLE, in_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0, cpu_reset=1, done=0, err=0, index=0, byte count=0.
REQ-033 Reset takes priority over start and in_valid in the same cycle.
REQ-034 Reset mid-load abandons the load with no further im_we pulses.

Verification
REQ-035 start; bytes 02, 00,00,88,21, 12,34,56,78 with in_valid continuous -> im_we at addr 0x3000 data 0x00008821, then at 0x3004 data 0x12345678; done=1, cpu_reset=0 in the cycle after the 2nd write.
REQ-036 start; N=00 -> err=1, cpu_reset=1, no im_we; then start; N=01 plus 4 bytes -> err=0, a single write at 0x3000, done=1.
REQ-037 N=DEPTH+1 (0x21) -> ERR; N=DEPTH (0x20) with 128 bytes -> 32 writes, last at 0x307C.
REQ-038 in_valid toggled randomly during BYTES -> identical write sequence; in_ready low during every WRITE cycle.
REQ-039 reset asserted after the 2nd byte of word 1 -> no im_we, state IDLE, cpu_reset=1; a fresh load then succeeds.
REQ-040 start pulsed during BYTES and in_valid held high in DONE -> no effect; done stays 1, no extra writes.
